sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares the single SDRAM Avalon-MM master port among up to `NUM_REQ` audio engines (mixer, recorder, player). Each engine uses the same hold-until-finished protocol. Grants are round-robin. Exactly one transaction is in flight at a time, and the winning requester gets a one-cycle `req_finished` pulse carrying read data. The block sits between the engine cores and the SDRAM controller.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 23: word address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum cycles to wait for `sdram_readdatavalid`.

Ports:
- `i_clk`  in  1  single clock; everything is synchronous to its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `req_read`  in  NUM_REQ  per-requester read request, held until finished.
- `req_write`  in  NUM_REQ  per-requester write request, held until finished.
- `req_addr`  in  ADDR_W x NUM_REQ  per-requester address.
- `req_writedata`  in  DATA_W x NUM_REQ  per-requester write data.
- `req_readdata`  out  DATA_W  shared read-data register.
- `req_finished`  out  NUM_REQ  one-hot completion pulse.
- `grant`  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- `sdram_address`  out  ADDR_W  SDRAM address.
- `sdram_read`  out  1  SDRAM read strobe.
- `sdram_write`  out  1  SDRAM write strobe.
- `sdram_writedata`  out  DATA_W  SDRAM write data.
- `sdram_readdata`  in  DATA_W  SDRAM read data.
- `sdram_waitrequest`  in  1  SDRAM stall.
- `sdram_readdatavalid`  in  1  SDRAM read data valid.
- `o_timeout`  out  1  sticky flag: a read timed out.

## Operation
- States:
  - IDLE: no transaction in flight.
  - ISSUE: command presented to SDRAM.
  - WAIT_DATA: read accepted, waiting for data.
  - DONE: completion pulse to the winner.
- A requester is active when `req_read[i] | req_write[i]`. If both are set, the request is treated as a read.
- IDLE:
  - If any requester is active, choose the winner `w`. Search starts at `last+1` and wraps modulo NUM_REQ; the first active index wins.
  - Latch `w`, the operation, `req_addr[w]` and `req_writedata[w]`. Set `last = w`. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive the latched address and data. Assert `sdram_read` or `sdram_write` and hold it while `sdram_waitrequest = 1`.
  - When `sdram_waitrequest = 0`: a write goes to DONE; a read goes to WAIT_DATA and clears the watchdog counter.
- WAIT_DATA:
  - Strobes are deasserted.
  - On `sdram_readdatavalid`: latch `sdram_readdata` into `req_readdata` and go to DONE.
  - If the counter reaches TIMEOUT first: load `req_readdata = 0`, set `o_timeout`, go to DONE.
  - Otherwise increment the counter.
- DONE: `req_finished[w] = 1` for exactly this cycle. Go to IDLE.
- `req_readdata` holds its value until the next read completes.
- `grant[w] = 1` from ISSUE through DONE.
- Requests are sampled only in IDLE. Once latched, a transaction always completes, even if the requester drops its request or changes its address mid-flight.
- Requesters deassert or advance on the edge after `req_finished`. The IDLE cycle that follows DONE therefore sees their updated requests, so no spurious re-grant occurs.
- Round-robin fairness: with all requesters continuously active, each is served once per NUM_REQ transactions.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - state = IDLE, `last = NUM_REQ-1` (so requester 0 wins first), watchdog counter = 0.
  - All outputs are 0, including `req_readdata`, `grant`, `req_finished`, SDRAM strobes and address, and `o_timeout`.
- All outputs are registered or decoded from state. No combinational path runs from `req_*` to `sdram_*`.
- Reset mid-transaction abandons the transaction: strobes drop immediately and no `req_finished` is issued.
- Write latency, request to `req_finished`: 3 cycles (IDLE sample, ISSUE, DONE) plus the number of `waitrequest` cycles.
- Read latency: 3 cycles plus `waitrequest` cycles plus the number of cycles until `readdatavalid`.
- Back-to-back transactions: minimum 3 cycles per transaction. Throughput is unchanged when the same requester re-requests.
- `sdram_readdatavalid` arriving outside WAIT_DATA is ignored.

## Test plan
- Reset, then requester 0 writes addr 0x000010 with data 0xDEADBEEF and `waitrequest = 0`:
  - One `sdram_write` cycle with those values.
  - `req_finished = 3'b001` on cycle 3.
  - `grant = 001` during ISSUE and DONE.
- Requester 1 reads 0x000020; `waitrequest` is held 2 cycles, then `readdatavalid` with 0x12345678 arrives 4 cycles after acceptance:
  - `sdram_read` is high for 3 cycles.
  - `req_readdata = 0x12345678` at the `req_finished = 010` pulse.
  - The value persists afterwards.
- All 3 requesters hold reads continuously:
  - Grant order is 0, 1, 2, 0, 1, 2.
  - No requester is finished twice before the others are served.
- Requester 2 read with `readdatavalid` never asserted (TIMEOUT = 255):
  - `req_finished = 100` arrives 255 cycles after acceptance.
  - `req_readdata = 0` and `o_timeout = 1`.
  - `o_timeout` stays high until `i_rst_n = 0`.
- Requester 0 drops its request the cycle after being latched, and `i_rst_n` is pulsed low during a later WAIT_DATA:
  - The first transaction still completes with `req_finished = 001`.
  - During reset, all outputs are 0 within the same cycle and no finished pulse is issued.
  - After reset, requester 0 has priority again.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that shares one SDRAM Avalon-MM master among NUM_REQ
// hold-until-finished engines, one transaction in flight at a time.
module sdram_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_finished,
  output logic [NUM_REQ-1:0]          grant,
  output logic [ADDR_W-1:0]           sdram_address,
  output logic                        sdram_read,
  output logic                        sdram_write,
  output logic [DATA_W-1:0]           sdram_writedata,
  input  logic [DATA_W-1:0]           sdram_readdata,
  input  logic                        sdram_waitrequest,
  input  logic                        sdram_readdatavalid,
  output logic                        o_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic            r_is_read;
  logic [CW-1:0]   r_cnt;

  logic [NUM_REQ-1:0] w_active;
  logic               w_any;
  logic [IW-1:0]      w_win;
  int unsigned        w_idx;
  logic               w_win_read;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data_arr[g] = req_writedata[g*DATA_W +: DATA_W];
  end

  assign w_active = req_read | req_write;

  // Scan from lowest to highest priority so the last hit is the nearest
  // active index after r_last (offset NUM_REQ is r_last itself).
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = (32'(r_last) + NUM_REQ - k) % NUM_REQ;
      if (w_active[IW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = IW'(w_idx);
      end
    end
  end

  assign w_addr     = w_addr_arr[w_win];
  assign w_wdata    = w_data_arr[w_win];
  assign w_win_read = req_read[w_win];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_last          <= IW'(NUM_REQ - 1);
      r_is_read       <= 1'b0;
      r_cnt           <= '0;
      req_readdata    <= '0;
      req_finished    <= '0;
      grant           <= '0;
      sdram_address   <= '0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_writedata <= '0;
      o_timeout       <= 1'b0;
    end else begin
      req_finished <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last          <= w_win;
            r_is_read       <= w_win_read;
            grant           <= NUM_REQ'(1) << w_win;
            sdram_address   <= w_addr;
            sdram_writedata <= w_wdata;
            sdram_read      <= w_win_read;
            sdram_write     <= !w_win_read;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sdram_waitrequest) begin
            sdram_read  <= 1'b0;
            sdram_write <= 1'b0;
            if (r_is_read) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_DATA;
            end else begin
              req_finished <= grant;
              r_state      <= S_DONE;
            end
          end
        end
        S_WAIT_DATA: begin
          if (sdram_readdatavalid) begin
            req_readdata <= sdram_readdata;
            req_finished <= grant;
            r_state      <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            req_readdata <= '0;
            o_timeout    <= 1'b1;
            req_finished <= grant;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          grant   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed cycle tables, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_sdram_arbiter;

  localparam int N  = 3;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 255;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [N-1:0]      req_read, req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_writedata;
  logic [DW-1:0]     req_readdata;
  logic [N-1:0]      req_finished, grant;
  logic [AW-1:0]     sdram_address;
  logic              sdram_read, sdram_write;
  logic [DW-1:0]     sdram_writedata;
  logic [DW-1:0]     sdram_readdata;
  logic              sdram_waitrequest, sdram_readdatavalid;
  logic              o_timeout;

  always #5 i_clk = ~i_clk;

  sdram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_writedata(req_writedata),
    .req_readdata(req_readdata), .req_finished(req_finished), .grant(grant),
    .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
    .sdram_waitrequest(sdram_waitrequest), .sdram_readdatavalid(sdram_readdatavalid),
    .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n             = 1'b0;
    req_read            = '0;
    req_write           = '0;
    req_addr            = '0;
    req_writedata       = '0;
    sdram_readdata      = '0;
    sdram_waitrequest   = 1'b0;
    sdram_readdatavalid = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
  endtask

  task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]      = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  function automatic int rr(input int last, input logic [N-1:0] act);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (act[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
    return ({9'h0, a} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [N-1:0]  rd, wr;
    logic          wt, vld;
    logic [DW-1:0] rdat;
    logic [N-1:0]  g, fin;
    logic          srd, swr;
    logic [DW-1:0] rdq;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[$];
    int cyc;
    logic [N-1:0] pend, isrd, both, act, exp_fin, exp_g;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rdq;
    logic m_isrd;
    int ph, mw, mcd, nwait, m_last, nfin;

    // write by 0 (0x10/DEADBEEF), then read by 1 (0x20) with 2 wait cycles
    // and data valid 4 cycles after acceptance, then a stray readdatavalid.
    //            rd      wr      wt   vld  rdat          g       fin     srd  swr  rdq           addr     wd
    tbl[0]  = '{3'b000, 3'b001, 1'b0, 1'b0, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 32'h0,        23'h10, 32'hDEADBEEF};
    tbl[1]  = '{3'b000, 3'b001, 1'b0, 1'b0, 32'h0,        3'b001, 3'b001, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[2]  = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[3]  = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[4]  = '{3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        23'h20, 32'h0};
    tbl[5]  = '{3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        23'h20, 32'h0};
    tbl[6]  = '{3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 32'h0,        23'h20, 32'h0};
    tbl[7]  = '{3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[8]  = '{3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[9]  = '{3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[10] = '{3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        3'b010, 3'b000, 1'b0, 1'b0, 32'h0,        23'h0,  32'h0};
    tbl[11] = '{3'b010, 3'b000, 1'b0, 1'b1, 32'h12345678, 3'b010, 3'b010, 1'b0, 1'b0, 32'h12345678, 23'h0,  32'h0};
    tbl[12] = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 32'h12345678, 23'h0,  32'h0};
    tbl[13] = '{3'b000, 3'b000, 1'b0, 1'b1, 32'hFFFF0000, 3'b000, 3'b000, 1'b0, 1'b0, 32'h12345678, 23'h0,  32'h0};

    do_reset();
    #1;
    chk("reset grant", grant, 0);
    chk("reset finished", req_finished, 0);
    chk("reset strobes", {sdram_read, sdram_write}, 0);
    chk("reset address", sdram_address, 0);
    chk("reset writedata", sdram_writedata, 0);
    chk("reset readdata", req_readdata, 0);
    chk("reset timeout", o_timeout, 0);

    set_lane(0, 23'h10, 32'hDEADBEEF);
    set_lane(1, 23'h20, 32'h0);
    set_lane(2, 23'h30, 32'h0);
    for (int k = 0; k < 14; k++) begin
      req_read            = tbl[k].rd;
      req_write           = tbl[k].wr;
      sdram_waitrequest   = tbl[k].wt;
      sdram_readdatavalid = tbl[k].vld;
      sdram_readdata      = tbl[k].rdat;
      tick();
      chk($sformatf("v%0d grant", k), grant, tbl[k].g);
      chk($sformatf("v%0d finished", k), req_finished, tbl[k].fin);
      chk($sformatf("v%0d sdram_read", k), sdram_read, tbl[k].srd);
      chk($sformatf("v%0d sdram_write", k), sdram_write, tbl[k].swr);
      chk($sformatf("v%0d readdata", k), req_readdata, tbl[k].rdq);
      if (tbl[k].srd || tbl[k].swr)
        chk($sformatf("v%0d address", k), sdram_address, tbl[k].addr);
      if (tbl[k].swr)
        chk($sformatf("v%0d writedata", k), sdram_writedata, tbl[k].wd);
    end

    // all three hold reads continuously: expect 0,1,2,0,1,2
    do_reset();
    set_lane(0, 23'h100, 0); set_lane(1, 23'h200, 0); set_lane(2, 23'h300, 0);
    req_read = 3'b111; sdram_waitrequest = 1'b0;
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'hCAFE0001;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      tick();
      if (req_finished != 0) begin
        chk("rr finished onehot", $onehot(req_finished), 1);
        order.push_back(oh2idx(req_finished));
      end
    end
    chk("rr finish count", order.size(), 6);
    for (int k = 0; k < order.size(); k++)
      chk($sformatf("rr order %0d", k), order[k], k % N);
    chk("rr readdata", req_readdata, 32'hCAFE0001);

    // requester 2 read, readdatavalid never comes
    req_read = 3'b100; sdram_readdatavalid = 1'b0;
    tick();
    tick();
    chk("to grant", grant, 3'b100);
    chk("to sdram_read", sdram_read, 1);
    tick();
    chk("to accepted", sdram_read, 0);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_finished == 0 && cyc < 400);
    chk("to latency", cyc, TO);
    chk("to finished", req_finished, 3'b100);
    chk("to readdata", req_readdata, 0);
    chk("to flag", o_timeout, 1);
    req_read = '0; req_write = 3'b001;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (req_finished == 0 && cyc < 10);
    chk("to next finished", req_finished, 3'b001);
    chk("to flag sticky", o_timeout, 1);
    req_write = '0;

    // request dropped after latch, then reset pulsed during WAIT_DATA
    do_reset();
    #1;
    chk("rst clears timeout", o_timeout, 0);
    set_lane(0, 23'h44, 32'h55);
    req_write = 3'b001;
    tick();
    chk("drop grant", grant, 3'b001);
    chk("drop address", sdram_address, 23'h44);
    chk("drop sdram_write", sdram_write, 1);
    req_write = '0;
    set_lane(0, 23'h99, 32'h66);
    tick();
    chk("drop finished", req_finished, 3'b001);
    req_read = 3'b001;
    tick();
    tick();
    chk("pre-rst read issued", sdram_read, 1);
    tick();
    tick();
    chk("pre-rst in wait", {grant, sdram_read}, {3'b001, 1'b0});
    #2 i_rst_n = 1'b0;
    #1;
    chk("async rst grant", grant, 0);
    chk("async rst strobes", {sdram_read, sdram_write}, 0);
    chk("async rst finished", req_finished, 0);
    chk("async rst address", sdram_address, 0);
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h77;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("in rst finished", req_finished, 0);
      chk("in rst readdata", req_readdata, 0);
    end
    i_rst_n = 1'b1;
    sdram_readdatavalid = 1'b0;
    req_read = 3'b011;
    tick();
    chk("post rst priority", grant, 3'b001);

    // randomized traffic against a transaction-level model
    do_reset();
    pend = '0; isrd = '0; both = '0;
    ph = 0; mw = 0; mcd = 0; nwait = 0; m_last = N - 1; nfin = 0;
    m_rdq = '0; m_isrd = 1'b0; m_addr = '0; m_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      act = req_read | req_write;
      exp_fin = '0;
      case (ph)
        0: if (act != 0) begin
          mw     = rr(m_last, act);
          m_last = mw;
          m_isrd = req_read[mw];
          m_addr = req_addr[mw*AW +: AW];
          m_wd   = req_writedata[mw*DW +: DW];
          ph     = 1;
        end
        1: if (!sdram_waitrequest) begin
          if (m_isrd) begin
            ph  = 2;
            mcd = $urandom_range(1, 5);
          end else begin
            ph = 3;
            exp_fin = N'(1) << mw;
          end
        end
        2: if (sdram_readdatavalid) begin
          ph = 3;
          exp_fin = N'(1) << mw;
          m_rdq = rdfun(m_addr);
        end
        default: ph = 0;
      endcase
      exp_g = (ph != 0) ? N'(1) << mw : '0;
      chk("rnd grant", grant, exp_g);
      chk("rnd finished", req_finished, exp_fin);
      chk("rnd sdram_read", sdram_read, ph == 1 && m_isrd);
      chk("rnd sdram_write", sdram_write, ph == 1 && !m_isrd);
      chk("rnd readdata", req_readdata, m_rdq);
      chk("rnd timeout", o_timeout, 0);
      if (ph == 1) chk("rnd address", sdram_address, m_addr);
      if (ph == 1 && !m_isrd) chk("rnd writedata", sdram_writedata, m_wd);

      if (exp_fin != 0) begin
        pend[mw] = 1'b0;
        nfin++;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          isrd[i] = 1'($urandom_range(0, 1));
          both[i] = ($urandom_range(0, 3) == 0);
          set_lane(i, AW'($urandom), $urandom);
        end
      end
      if (ph != 0 && $urandom_range(0, 2) == 0) set_lane(mw, AW'($urandom), $urandom);
      req_read  = pend & isrd;
      req_write = pend & (~isrd | both);
      if (ph == 1) begin
        if (nwait < 4 && $urandom_range(0, 1) == 1) begin
          sdram_waitrequest = 1'b1;
          nwait++;
        end else begin
          sdram_waitrequest = 1'b0;
          nwait = 0;
        end
      end else begin
        sdram_waitrequest = 1'($urandom_range(0, 1));
      end
      sdram_readdata = $urandom;
      if (ph == 2) begin
        mcd--;
        sdram_readdatavalid = (mcd == 0);
        if (mcd == 0) sdram_readdata = rdfun(m_addr);
      end else begin
        sdram_readdatavalid = ($urandom_range(0, 7) == 0);
      end
    end
    chk("rnd progress", nfin > 100, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
